armleocpu_plic_gateway: RTL and testbench

ARMLEOCPU_PLIC_GATEWAY -- requirements
Module: armleocpu_plic_gateway

---
 rtl/armleocpu_plic_gateway.sv | 105 ++++++++++
 tb/tb_armleocpu_plic_gateway.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_plic_gateway.sv
// PLIC interrupt gateway: per-source IDLE/PENDING/CLAIMED tracking with claim/complete handshake.
// Optional per-source edge-triggered mode is enabled by defining ARMLEOCPU_PLIC_EDGE_EN.
module armleocpu_plic_gateway #(
    parameter int INTERRUPT_SOURCE_COUNT = 32,
    parameter int ID_WIDTH               = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [INTERRUPT_SOURCE_COUNT-1:0] irq,
`ifdef ARMLEOCPU_PLIC_EDGE_EN
    input  logic [INTERRUPT_SOURCE_COUNT-1:0] irq_edge_mode,
`endif
    input  logic                              claim_valid,
    input  logic [ID_WIDTH-1:0]               claim_id,
    input  logic                              complete_valid,
    input  logic [ID_WIDTH-1:0]               complete_id,
    output logic [INTERRUPT_SOURCE_COUNT-1:0] pending,
    output logic [INTERRUPT_SOURCE_COUNT-1:0] claimed
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] CLAIMED = 2'd2;

    logic [INTERRUPT_SOURCE_COUNT-1:0][1:0] state;
    logic [INTERRUPT_SOURCE_COUNT-1:0][1:0] state_nxt;
    logic [INTERRUPT_SOURCE_COUNT-1:0]      trigger;

`ifdef ARMLEOCPU_PLIC_EDGE_EN
    logic [INTERRUPT_SOURCE_COUNT-1:0] irq_prev;
    logic [INTERRUPT_SOURCE_COUNT-1:0] edge_flag;
    logic [INTERRUPT_SOURCE_COUNT-1:0] edge_flag_nxt;
    logic [INTERRUPT_SOURCE_COUNT-1:0] irq_rise;

    assign irq_rise = irq & ~irq_prev;
    // Edge sources fire on a fresh rising edge or one remembered while busy.
    assign trigger  = (irq_edge_mode & (irq_rise | edge_flag)) | (~irq_edge_mode & irq);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev  <= '0;
            edge_flag <= '0;
        end else begin
            irq_prev  <= irq;
            edge_flag <= edge_flag_nxt;
        end
    end
`else
    assign trigger = irq;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
`ifdef ARMLEOCPU_PLIC_EDGE_EN
        edge_flag_nxt = edge_flag;
`endif
        for (int i = 0; i < INTERRUPT_SOURCE_COUNT; i++) begin
            case (state[i])
                IDLE: begin
                    if (trigger[i]) begin
                        state_nxt[i] = PENDING;
`ifdef ARMLEOCPU_PLIC_EDGE_EN
                        edge_flag_nxt[i] = 1'b0;
`endif
                    end
                end
                PENDING: begin
                    if (claim_valid && (claim_id == ID_WIDTH'(i + 1)))
                        state_nxt[i] = CLAIMED;
`ifdef ARMLEOCPU_PLIC_EDGE_EN
                    if (irq_edge_mode[i] && irq_rise[i])
                        edge_flag_nxt[i] = 1'b1;
`endif
                end
                CLAIMED: begin
                    if (complete_valid && (complete_id == ID_WIDTH'(i + 1)))
                        state_nxt[i] = IDLE;
`ifdef ARMLEOCPU_PLIC_EDGE_EN
                    if (irq_edge_mode[i] && irq_rise[i])
                        edge_flag_nxt[i] = 1'b1;
`endif
                end
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        pending = '0;
        claimed = '0;
        for (int i = 0; i < INTERRUPT_SOURCE_COUNT; i++) begin
            pending[i] = (state[i] == PENDING);
            claimed[i] = (state[i] == CLAIMED);
        end
    end

endmodule

// File: tb/tb_armleocpu_plic_gateway.sv
// Directed testbench for armleocpu_plic_gateway (level mode; edge mode when ARMLEOCPU_PLIC_EDGE_EN is defined).
module tb_armleocpu_plic_gateway;

    logic        clk;
    logic        rst;
    logic [31:0] irq;
    logic [31:0] irq_edge_mode;
    logic        claim_valid;
    logic [9:0]  claim_id;
    logic        complete_valid;
    logic [9:0]  complete_id;
    logic [31:0] pending;
    logic [31:0] claimed;

    int checks;
    int failures;

    armleocpu_plic_gateway #(
        .INTERRUPT_SOURCE_COUNT(32),
        .ID_WIDTH(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq(irq),
`ifdef ARMLEOCPU_PLIC_EDGE_EN
        .irq_edge_mode(irq_edge_mode),
`endif
        .claim_valid(claim_valid),
        .claim_id(claim_id),
        .complete_valid(complete_valid),
        .complete_id(complete_id),
        .pending(pending),
        .claimed(claimed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock edge, then sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
        check("exclusive", pending & claimed, 32'h0);
    endtask

    task automatic expect_state(input string tag, input logic [31:0] p, input logic [31:0] c);
        check({tag, "_pending"}, pending, p);
        check({tag, "_claimed"}, claimed, c);
    endtask

    task automatic strobes(input logic cv, input logic [9:0] cid, input logic pv, input logic [9:0] pid);
        claim_valid    = cv;
        claim_id       = cid;
        complete_valid = pv;
        complete_id    = pid;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        irq           = 32'h0;
        irq_edge_mode = 32'h0;
        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        step();
        rst = 1'b0;
        expect_state("reset", 32'h0, 32'h0);

        irq = 32'h4;
        step();
        expect_state("irq2_pend", 32'h4, 32'h0);

        strobes(1'b1, 10'd5, 1'b0, 10'd0);
        step();
        expect_state("claim_idle_src", 32'h4, 32'h0);

        strobes(1'b1, 10'd3, 1'b0, 10'd0);
        step();
        expect_state("claim3", 32'h0, 32'h4);

        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        irq = 32'h5;
        step();
        expect_state("src0_pend", 32'h1, 32'h4);

        irq = 32'h4;
        step();
        expect_state("deassert_kept", 32'h1, 32'h4);

        strobes(1'b1, 10'd1, 1'b1, 10'd3);
        step();
        expect_state("claim_complete", 32'h0, 32'h1);

        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        step();
        expect_state("level_repend", 32'h4, 32'h1);

        strobes(1'b1, 10'd0, 1'b0, 10'd0);
        step();
        expect_state("claim_id0", 32'h4, 32'h1);

        strobes(1'b1, 10'd33, 1'b1, 10'd33);
        step();
        expect_state("id33", 32'h4, 32'h1);

        strobes(1'b1, 10'd1, 1'b1, 10'd3);
        step();
        expect_state("wrong_state", 32'h4, 32'h1);

        strobes(1'b1, 10'd3, 1'b1, 10'd3);
        step();
        expect_state("same_id", 32'h0, 32'h5);

        strobes(1'b0, 10'd0, 1'b1, 10'd1);
        irq = 32'h4;
        step();
        expect_state("complete1", 32'h0, 32'h4);

        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        irq = 32'h5;
        step();
        expect_state("pre_reset", 32'h1, 32'h4);

        rst = 1'b1;
        strobes(1'b1, 10'd1, 1'b1, 10'd3);
        step();
        expect_state("reset_prio", 32'h0, 32'h0);

        rst = 1'b0;
        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        step();
        expect_state("post_reset", 32'h5, 32'h0);

        irq = 32'h8000_0005;
        step();
        expect_state("src31_pend", 32'h8000_0005, 32'h0);

        strobes(1'b1, 10'd32, 1'b0, 10'd0);
        step();
        expect_state("claim32", 32'h5, 32'h8000_0000);

        strobes(1'b0, 10'd0, 1'b1, 10'd32);
        irq = 32'h5;
        step();
        expect_state("complete32", 32'h5, 32'h0);
        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        step();
        expect_state("src31_idle", 32'h5, 32'h0);

`ifdef ARMLEOCPU_PLIC_EDGE_EN
        rst           = 1'b1;
        irq           = 32'h0;
        irq_edge_mode = 32'h2;
        step();
        rst = 1'b0;
        expect_state("e_reset", 32'h0, 32'h0);

        irq = 32'h2;
        step();
        expect_state("e_rise", 32'h2, 32'h0);
        strobes(1'b1, 10'd2, 1'b0, 10'd0);
        step();
        expect_state("e_claim", 32'h0, 32'h2);
        strobes(1'b0, 10'd0, 1'b0, 10'd0);

        irq = 32'h0;
        step();
        irq = 32'h2;
        step();
        irq = 32'h0;
        step();
        irq = 32'h2;
        step();
        irq = 32'h0;
        expect_state("e_pulses", 32'h0, 32'h2);

        strobes(1'b0, 10'd0, 1'b1, 10'd2);
        step();
        expect_state("e_complete", 32'h0, 32'h0);
        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        step();
        expect_state("e_flag_pend", 32'h2, 32'h0);

        strobes(1'b1, 10'd2, 1'b0, 10'd0);
        step();
        strobes(1'b0, 10'd0, 1'b1, 10'd2);
        step();
        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        step();
        expect_state("e_coalesced", 32'h0, 32'h0);

        irq = 32'h2;
        step();
        expect_state("e_rise2", 32'h2, 32'h0);
        strobes(1'b1, 10'd2, 1'b0, 10'd0);
        step();
        strobes(1'b0, 10'd0, 1'b1, 10'd2);
        step();
        strobes(1'b0, 10'd0, 1'b0, 10'd0);
        step();
        step();
        expect_state("e_const_high", 32'h0, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
